// File: rtl/nano_mem_line_responder.sv
// Line-level memory responder for the NanoCache instr/data ports: arbitrates line requests and
// serialises each 8x32b line into 8 beats on a single-port, 1-cycle-latency SRAM.
module nano_mem_line_responder #(
    parameter int SRAM_AW = 14
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_mm_rden_instr,
    input  logic [31:0]         i_mm_addr_instr,
    output logic                o_mm_gnt_instr,
    output logic                o_mm_rvalid_instr,
    output logic [7:0][31:0]    o_mm_rdata_instr,
    input  logic                i_mm_rden_data,
    input  logic                i_mm_wren_data,
    input  logic [31:0]         i_mm_addr_data,
    input  logic [7:0][31:0]    i_mm_wdata_data,
    output logic                o_mm_gnt_data,
    output logic                o_mm_rvalid_data,
    output logic [7:0][31:0]    o_mm_rdata_data,
    output logic                o_sram_en,
    output logic                o_sram_we,
    output logic [SRAM_AW-1:0]  o_sram_addr,
    output logic [31:0]         o_sram_wdata,
    input  logic [31:0]         i_sram_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DRAIN,
        ST_RESP,
        ST_WR
    } state_t;

    state_t               state;
    logic [2:0]           beat;
    logic [2:0]           next_beat;
    logic [SRAM_AW-4:0]   base;
    logic [SRAM_AW-4:0]   sel_base;
    logic [7:0][31:0]     line;
    logic [7:0][31:0]     line_final;
    logic                 owner_data;
    logic                 rr_data_next;
    logic                 cap_valid;
    logic [2:0]           cap_idx;
    logic                 instr_req;
    logic                 data_req;
    logic                 pick_data;
    logic                 unused_addr_bits;

    // The port not served last wins a tie; a lone requester is always served.
    always_comb begin
        instr_req  = i_mm_rden_instr;
        data_req   = i_mm_rden_data | i_mm_wren_data;
        pick_data  = data_req & (~instr_req | rr_data_next);
        sel_base   = pick_data ? i_mm_addr_data[SRAM_AW+1:5] : i_mm_addr_instr[SRAM_AW+1:5];
        next_beat  = beat + 3'd1;
        line_final = line;
        line_final[7] = i_sram_rdata;
    end

    assign unused_addr_bits = ^{i_mm_addr_instr[31:SRAM_AW+2], i_mm_addr_instr[4:0],
                                i_mm_addr_data[31:SRAM_AW+2], i_mm_addr_data[4:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= ST_IDLE;
            beat              <= '0;
            base              <= '0;
            line              <= '0;
            owner_data        <= 1'b0;
            rr_data_next      <= 1'b0;
            cap_valid         <= 1'b0;
            cap_idx           <= '0;
            o_mm_gnt_instr    <= 1'b0;
            o_mm_rvalid_instr <= 1'b0;
            o_mm_rdata_instr  <= '0;
            o_mm_gnt_data     <= 1'b0;
            o_mm_rvalid_data  <= 1'b0;
            o_mm_rdata_data   <= '0;
            o_sram_en         <= 1'b0;
            o_sram_we         <= 1'b0;
            o_sram_addr       <= '0;
            o_sram_wdata      <= '0;
        end else begin
            o_mm_gnt_instr    <= 1'b0;
            o_mm_gnt_data     <= 1'b0;
            o_mm_rvalid_instr <= 1'b0;
            o_mm_rvalid_data  <= 1'b0;

            // Read words return one cycle after their address beat.
            cap_valid <= o_sram_en & ~o_sram_we;
            cap_idx   <= beat;
            if (cap_valid) begin
                line[cap_idx] <= i_sram_rdata;
            end

            case (state)
                ST_IDLE: begin
                    if (instr_req | data_req) begin
                        owner_data    <= pick_data;
                        rr_data_next  <= ~pick_data;
                        base          <= sel_base;
                        beat          <= '0;
                        o_mm_gnt_data <= pick_data;
                        o_mm_gnt_instr <= ~pick_data;
                        o_sram_en     <= 1'b1;
                        o_sram_addr   <= {sel_base, 3'd0};
                        // A simultaneous read+write on the data port takes the write first.
                        if (pick_data && i_mm_wren_data) begin
                            state        <= ST_WR;
                            line         <= i_mm_wdata_data;
                            o_sram_we    <= 1'b1;
                            o_sram_wdata <= i_mm_wdata_data[0];
                        end else begin
                            state        <= ST_RD;
                            o_sram_we    <= 1'b0;
                            o_sram_wdata <= '0;
                        end
                    end
                end
                ST_RD: begin
                    beat <= next_beat;
                    if (beat == 3'd7) begin
                        state       <= ST_DRAIN;
                        o_sram_en   <= 1'b0;
                        o_sram_addr <= '0;
                    end else begin
                        o_sram_addr <= {base, next_beat};
                    end
                end
                ST_WR: begin
                    beat <= next_beat;
                    if (beat == 3'd7) begin
                        state        <= ST_IDLE;
                        o_sram_en    <= 1'b0;
                        o_sram_we    <= 1'b0;
                        o_sram_addr  <= '0;
                        o_sram_wdata <= '0;
                    end else begin
                        o_sram_addr  <= {base, next_beat};
                        o_sram_wdata <= line[next_beat];
                    end
                end
                ST_DRAIN: begin
                    state <= ST_RESP;
                    if (owner_data) begin
                        o_mm_rvalid_data <= 1'b1;
                        o_mm_rdata_data  <= line_final;
                    end else begin
                        o_mm_rvalid_instr <= 1'b1;
                        o_mm_rdata_instr  <= line_final;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
